// File: rtl/tick_sched_pkg.sv
// Shared opcode values and event-port state encoding for tick_scheduler.
package tick_sched_pkg;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } evt_state_e;

endpackage

// File: rtl/tick_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// N must be a power of two so the index arithmetic wraps for free.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  // Scan from the farthest offset down so the nearest request is written last.
  always_comb begin
    grant_idx = ptr;
    any       = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[ptr + IW'(i)]) begin
        grant_idx = ptr + IW'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Shared-prescaler multi-channel timer with a round-robin expiry event port.
// Define TICK_SCHED_PERIODIC_EN to enable periodic channels; otherwise all are one-shot.
//
// state   | meaning
// S_IDLE  | no offer; picks the next pending channel round-robin from ptr
// S_OFFER | evt_ch is offered until consumed or cleared
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int DIV = 500000,
  localparam int CHW = $clog2(NCH),
  localparam int PW  = $clog2(DIV)
) (
  input  logic           CLK,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [CHW-1:0] cmd_ch,
  input  logic [CW-1:0]  cmd_data,
  output logic           tick,
  output logic [NCH-1:0] run,
  output logic [NCH-1:0] overrun,
  output logic           evt_valid,
  output logic [CHW-1:0] evt_ch,
  input  logic           evt_ready
);

  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);

  logic [PW-1:0]  pcnt;
  logic           cmd_fire;
  logic           clear_offered;
  logic           evt_done;
  logic [NCH-1:0] pending;

  evt_state_e     state_q, state_d;
  logic [CHW-1:0] evt_ch_q, evt_ch_d;
  logic [CHW-1:0] ptr_q, ptr_d;
  logic [CHW-1:0] grant_idx;
  logic           grant_any;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (pcnt == PCNT_LAST) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // Commands are refused on tick so a channel never sees a command and a decrement together.
  assign tick      = (pcnt == PCNT_LAST);
  assign cmd_ready = ~tick;
  assign cmd_fire  = cmd_valid & cmd_ready;

  assign clear_offered = cmd_fire && (cmd_op == OP_CLEAR) && (cmd_ch == evt_ch_q);
  assign evt_done      = evt_valid && (evt_ready || clear_offered);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] reload_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;
    logic          pend_q;
    logic          ovr_q;
    logic          sel;
    logic          clr;
    logic          expire;
    logic          served;

    assign sel    = cmd_fire && (cmd_ch == CHW'(i));
    assign clr    = sel && (cmd_op == OP_CLEAR);
    assign expire = tick && run_q && (cnt_q == CW'(1));
    assign served = evt_done && (evt_ch_q == CHW'(i));

`ifdef TICK_SCHED_PERIODIC_EN
    logic per_q;

    always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
        per_q <= 1'b0;
      end else if (sel && (cmd_op == OP_START) && (reload_q != '0)) begin
        per_q <= cmd_data[0];
      end
    end
`endif

    always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
        reload_q <= '0;
        cnt_q    <= '0;
        run_q    <= 1'b0;
      end else if (tick) begin
        if (expire) begin
`ifdef TICK_SCHED_PERIODIC_EN
          cnt_q <= per_q ? reload_q : '0;
          run_q <= per_q;
`else
          cnt_q <= '0;
          run_q <= 1'b0;
`endif
        end else if (run_q) begin
          cnt_q <= cnt_q - CW'(1);
        end
      end else if (sel) begin
        unique case (cmd_op)
          OP_LOAD: begin
            reload_q <= cmd_data;
            cnt_q    <= '0;
            run_q    <= 1'b0;
          end
          OP_START: begin
            if (reload_q != '0) begin
              cnt_q <= reload_q;
              run_q <= 1'b1;
            end
          end
          OP_STOP:  run_q <= 1'b0;
          OP_CLEAR: ;
        endcase
      end
    end

    // A new expiry beats a same-cycle consume, so the channel stays pending.
    always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
        pend_q <= 1'b0;
        ovr_q  <= 1'b0;
      end else begin
        if (expire) begin
          pend_q <= 1'b1;
          if (pend_q && !served) begin
            ovr_q <= 1'b1;
          end
        end else if (served || clr) begin
          pend_q <= 1'b0;
        end
        if (clr) begin
          ovr_q <= 1'b0;
        end
      end
    end

    assign run[i]     = run_q;
    assign pending[i] = pend_q;
    assign overrun[i] = ovr_q;
  end

  rr_arbiter #(.N(NCH)) u_arb (
    .req       (pending),
    .ptr       (ptr_q),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      evt_ch_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      evt_ch_q <= evt_ch_d;
      ptr_q    <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    evt_ch_d = evt_ch_q;
    ptr_d    = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          state_d  = S_OFFER;
          evt_ch_d = grant_idx;
        end
      end
      S_OFFER: begin
        if (evt_done) begin
          state_d = S_IDLE;
          ptr_d   = evt_ch_q + CHW'(1);
        end
      end
    endcase
  end

  always_comb begin
    evt_valid = (state_q == S_OFFER);
    evt_ch    = evt_ch_q;
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler (DIV=4, NCH=4, CW=8): behavioural model compared every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_tick_scheduler;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int DIV = 4;

`ifdef TICK_SCHED_PERIODIC_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [1:0]     cmd_op = 2'd0;
  logic [1:0]     cmd_ch = 2'd0;
  logic [CW-1:0]  cmd_data = '0;
  logic           tick;
  logic [NCH-1:0] run;
  logic [NCH-1:0] overrun;
  logic           evt_valid;
  logic [1:0]     evt_ch;
  logic           evt_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;

  tick_scheduler #(.NCH(NCH), .CW(CW), .DIV(DIV)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_ch    (cmd_ch),
    .cmd_data  (cmd_data),
    .tick      (tick),
    .run       (run),
    .overrun   (overrun),
    .evt_valid (evt_valid),
    .evt_ch    (evt_ch),
    .evt_ready (evt_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycles since reset release; the prescaler phase is cyc mod DIV.
  always @(posedge CLK or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Reference model: channel timers, pending flags and a one-slot offer with a rotating start index.
  bit m_run[NCH];
  bit m_per[NCH];
  bit m_pend[NCH];
  bit m_ovr[NCH];
  int m_cnt[NCH];
  int m_rel[NCH];
  bit m_off = 1'b0;
  int m_och = 0;
  int m_ptr = 0;

  always @(posedge CLK or posedge rst) begin : model
    bit tk, fire, cons, clr_i, exp_i, found;
    int idx;
    bit n_run[NCH];
    bit n_per[NCH];
    bit n_pend[NCH];
    bit n_ovr[NCH];
    int n_cnt[NCH];
    int n_rel[NCH];
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_run[i] <= 1'b0; m_per[i] <= 1'b0; m_pend[i] <= 1'b0;
        m_ovr[i] <= 1'b0; m_cnt[i] <= 0;    m_rel[i]  <= 0;
      end
      m_off <= 1'b0;
      m_och <= 0;
      m_ptr <= 0;
    end else begin
      n_run = m_run; n_per = m_per; n_pend = m_pend;
      n_ovr = m_ovr; n_cnt = m_cnt; n_rel = m_rel;
      tk   = (cyc % DIV) == DIV - 1;
      fire = cmd_valid && !tk;
      cons = m_off && (evt_ready || (fire && cmd_op == 2'd3 && int'(cmd_ch) == m_och));
      for (int i = 0; i < NCH; i++) begin
        clr_i = fire && cmd_op == 2'd3 && int'(cmd_ch) == i;
        exp_i = tk && m_run[i] && m_cnt[i] == 1;
        if (exp_i) begin
          n_run[i] = m_per[i];
          n_cnt[i] = m_per[i] ? m_rel[i] : 0;
        end else if (tk && m_run[i]) begin
          n_cnt[i] = m_cnt[i] - 1;
        end else if (fire && int'(cmd_ch) == i) begin
          case (cmd_op)
            2'd0: begin n_rel[i] = int'(cmd_data); n_run[i] = 1'b0; n_cnt[i] = 0; end
            2'd1: if (m_rel[i] != 0) begin
                    n_cnt[i] = m_rel[i]; n_run[i] = 1'b1; n_per[i] = PER_EN & cmd_data[0];
                  end
            2'd2: n_run[i] = 1'b0;
            default: ;
          endcase
        end
        if (exp_i) begin
          if (m_pend[i] && !(cons && m_och == i)) n_ovr[i] = 1'b1;
          n_pend[i] = 1'b1;
        end else if ((cons && m_och == i) || clr_i) begin
          n_pend[i] = 1'b0;
        end
        if (clr_i) n_ovr[i] = 1'b0;
      end
      if (m_off) begin
        if (cons) begin
          m_off <= 1'b0;
          m_ptr <= (m_och + 1) % NCH;
        end
      end else begin
        found = 1'b0;
        for (int j = 0; j < NCH; j++) begin
          idx = (m_ptr + j) % NCH;
          if (!found && m_pend[idx]) begin
            found = 1'b1;
            m_och <= idx;
            m_off <= 1'b1;
          end
        end
      end
      m_run <= n_run; m_per <= n_per; m_pend <= n_pend;
      m_ovr <= n_ovr; m_cnt <= n_cnt; m_rel <= n_rel;
    end
  end

  always @(negedge CLK) begin : compare
    logic [NCH-1:0] e_run, e_ovr;
    bit e_tick;
    if (!rst) begin
      e_tick = (cyc % DIV) == DIV - 1;
      for (int i = 0; i < NCH; i++) begin
        e_run[i] = m_run[i];
        e_ovr[i] = m_ovr[i];
      end
      check("tick", tick, e_tick);
      check("cmd_ready", cmd_ready, !e_tick);
      check("run", run, e_run);
      check("overrun", overrun, e_ovr);
      check("evt_valid", evt_valid, m_off);
      check("evt_ch", evt_ch, m_och);
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic send(input logic [1:0] op, input int ch, input int data);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ch    = 2'(ch);
    cmd_data  = CW'(data);
    n = 0;
    while (!cmd_ready && n < 4) begin
      step();
      n++;
    end
    if (n == 4) check("send_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (!tick && n < 2 * DIV) begin
      step();
      n++;
    end
    if (n == 2 * DIV) check("tick_timeout", tick, 1);
  endtask

  task automatic collect3(input string name);
    int got[$];
    int tms[$];
    for (int n = 0; n < 40 && got.size() < 3; n++) begin
      if (evt_valid) begin
        got.push_back(int'(evt_ch));
        tms.push_back(cyc);
      end
      step();
    end
    check({name, "_count"}, got.size(), 3);
    if (got.size() == 3) begin
      check({name, "_ch0"}, got[0], 0);
      check({name, "_ch1"}, got[1], 2);
      check({name, "_ch2"}, got[2], 3);
      check({name, "_gap0"}, tms[1] - tms[0], 2);
      check({name, "_gap1"}, tms[2] - tms[1], 2);
    end
  endtask

  initial begin : stim
    int t_evt, n, cnt;
    int times[$];

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Reset values and tick cadence: tick high at cycles 3, 7, 11.
    for (int k = 0; k < 12; k++) begin
      check("tick_seq", tick, (k % 4) == 3);
      if (k < 3) begin
        check("rst_run", run, 0);
        check("rst_overrun", overrun, 0);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_cmd_ready", cmd_ready, 1);
      end
      step();
    end

    // One-shot: START accepted at cycle 13, ticks at 15/19/23, event offered at 25.
    send(2'd0, 1, 3);
    send(2'd1, 1, 0);
    n = 0;
    while (!evt_valid && n < 60) begin step(); n++; end
    check("oneshot_evt_cycle", cyc, 25);
    check("oneshot_evt_ch", evt_ch, 1);
    check("oneshot_run1", run[1], 0);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("oneshot_consumed", evt_valid, 0);

    // Periodic channel 0 with reload 2.
    evt_ready = 1'b1;
    send(2'd0, 0, 2);
    send(2'd1, 0, 1);
`ifdef TICK_SCHED_PERIODIC_EN
    times.delete();
    for (n = 0; n < 100 && times.size() < 3; n++) begin
      if (evt_valid) times.push_back(cyc);
      step();
    end
    check("per_count", times.size(), 3);
    if (times.size() == 3) begin
      check("per_gap0", times[1] - times[0], 8);
      check("per_gap1", times[2] - times[1], 8);
    end
    check("per_run0", run[0], 1);
    send(2'd2, 0, 0);
    repeat (4) step();
    cnt = 0;
    repeat (20) begin
      if (evt_valid) cnt++;
      step();
    end
    check("per_stopped_events", cnt, 0);
`else
    n = 0;
    while (!evt_valid && n < 60) begin step(); n++; end
    check("noper_evt_ch", evt_ch, 0);
    check("noper_run0", run[0], 0);
    step();
`endif

    // Round-robin: channels 0, 2, 3 expire on one tick; delivery 0, 2, 3, twice.
    rst = 1'b1;
    step();
    rst = 1'b0;
    evt_ready = 1'b1;
    send(2'd0, 0, 1);
    send(2'd0, 2, 1);
    send(2'd0, 3, 1);
    for (int r = 0; r < 2; r++) begin
      wait_tick();
      step();
      send(2'd1, 0, 0);
      send(2'd1, 2, 0);
      send(2'd1, 3, 0);
      collect3("rr");
    end

    // Overrun and CLEAR on channel 1 with reload 1, event left unconsumed.
    evt_ready = 1'b0;
    repeat (3) step();
    send(2'd0, 1, 1);
    send(2'd1, 1, 1);
    wait_tick();
    step();
`ifndef TICK_SCHED_PERIODIC_EN
    send(2'd1, 1, 1);
`endif
    wait_tick();
    step();
    check("ovr_set", overrun[1], 1);
    check("ovr_evt_valid", evt_valid, 1);
    check("ovr_evt_ch", evt_ch, 1);
    send(2'd3, 1, 0);
    check("clr_overrun", overrun[1], 0);
    check("clr_evt_valid", evt_valid, 0);
    send(2'd2, 1, 0);
    send(2'd3, 1, 0);

    // Command blocked in a tick cycle, taken on the next one; START with reload 0 is ignored.
    send(2'd0, 2, 5);
    wait_tick();
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_ch    = 2'd2;
    cmd_data  = '0;
    check("blk_ready_low", cmd_ready, 0);
    step();
    check("blk_ready_high", cmd_ready, 1);
    check("blk_run2_pending", run[2], 0);
    step();
    cmd_valid = 1'b0;
    check("blk_run2_taken", run[2], 1);
    send(2'd0, 3, 0);
    send(2'd1, 3, 1);
    check("zero_reload_run3", run[3], 0);
    step();
    check("zero_reload_run3_later", run[3], 0);
    send(2'd2, 2, 0);

    // Randomized traffic with occasional mid-run resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_ch    = 2'($urandom_range(0, 3));
      cmd_data  = CW'($urandom_range(0, 3));
      evt_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    cmd_valid = 1'b0;
    evt_ready = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel timer controller built around one shared prescaler. It divides `CLK` into a single-cycle `tick` enable and runs `NCH` programmable down-counting channels on that tick. Each channel can run one-shot or periodic. Expirations are queued per channel and handed out one at a time through a round-robin valid/ready event port. It replaces the per-use free-running dividers in lab designs such as stopwatch, display scan and debounce, and shares one divider among them.

## Interface
- `NCH`, 4: number of channels; must be a power of two, 2..8.
- `CW`, 16: channel count width.
- `DIV`, 500000: prescaler period in `CLK` cycles, ≥2.
- `CLK` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_op` input 2: opcode. 0 LOAD, 1 START, 2 STOP, 3 CLEAR.
- `cmd_ch` input log2(NCH): target channel.
- `cmd_data` input CW: LOAD reload value; START uses bit0 as the periodic flag.
- `tick` output 1: one-cycle prescaler pulse.
- `run` output NCH: channel running.
- `overrun` output NCH: sticky; an expiry occurred while that channel's event was still pending.
- `evt_valid` output 1: event offered.
- `evt_ch` output log2(NCH): expired channel.
- `evt_ready` input 1: event consumed when both `evt_valid` and `evt_ready` are high.

## Operation
- **Prescaler:** `pcnt` counts 0..DIV-1 and wraps. `tick`=1 exactly when `pcnt`==DIV-1, so the period is DIV cycles. It is free-running and is not affected by commands.
- **`cmd_ready`:** equals `~tick`. No command is accepted in a tick cycle, so commands and counting never coincide.
- **LOAD:** `reload[ch]`←data, `run[ch]`←0, `cnt[ch]`←0.
- **START:**
  - If `reload[ch]`==0 it is a no-op.
  - Otherwise `cnt[ch]`←`reload[ch]`, `per[ch]`←data[0], `run[ch]`←1. Restarting a running channel reloads it.
- **STOP:** `run[ch]`←0. `cnt` is held.
- **CLEAR:** `pending[ch]`←0 and `overrun[ch]`←0. If `ch` is currently offered on the event port, the offer is completed as if accepted.
- **On tick, for each running channel:**
  - If `cnt`==1: expire. Set `pending`. If `per`, `cnt`←`reload`; otherwise `cnt`←0 and `run`←0.
  - Otherwise `cnt`←`cnt`-1.
- **Overrun:** an expiry while `pending` is already 1 and not being cleared that cycle sets `overrun`. If an expiry and a clear of the same channel coincide, set wins: `pending` stays 1 and `overrun` is unchanged.
- **Event FSM:**
  - IDLE: if any `pending`, latch the round-robin winner starting at `ptr` into `evt_ch`, then go to OFFER.
  - OFFER: `evt_valid`=1 and `evt_ch` is held stable. On `evt_ready`, clear `pending[evt_ch]`, set `ptr`←`evt_ch`+1 (mod NCH), and return to IDLE.

## Timing
- **Reset values:** `pcnt`=0, `tick`=0, `cmd_ready`=1, `run`=0, `overrun`=0, `pending`=0, `reload`=0, `cnt`=0, `per`=0, `ptr`=0, FSM=IDLE, `evt_valid`=0, `evt_ch`=0.
- **Tick timing:** `tick` is first high in cycle DIV-1 after reset release.
- **START to first expiry:** START accepted in cycle c with reload R → expiry on the R-th tick after c.
- **Expiry to event:** expiry on the tick at cycle t → `pending` high at t+1 → `evt_valid` high at t+2.
- **Back-to-back events:** at most one event per 2 cycles (OFFER→IDLE→OFFER).
- **Reset mid-operation:** asserting `rst` clears everything immediately and asynchronously. In-flight events are dropped.

## Configuration
- **`TICK_SCHED_PERIODIC_EN` defined:** periodic mode as described above.
- **Undefined:**
  - `per` registers are removed and START ignores data[0].
  - All channels are one-shot: they stop on expiry.
  - `overrun` can still be set, by a restart that expires again before the event is consumed.

## Structure
- **Package `tick_sched_pkg`:**
  - Opcode constants `OP_LOAD`/`OP_START`/`OP_STOP`/`OP_CLEAR`.
  - FSM state encodings `S_IDLE`/`S_OFFER`.
- **Sub-module `rr_arbiter`:** combinational round-robin pick. Inputs are the request vector and `ptr`; outputs are `grant_idx` and `any`. It is reusable elsewhere.
- **Top level:** the prescaler, the channel array (generate loop) and the FSM live in `tick_scheduler`.

## Test plan
All scenarios use DIV=4, NCH=4, CW=8.
- **Reset and tick:** release `rst` → `tick` high in cycles 3, 7, 11…; all outputs are at their reset values before that.
- **One-shot:** LOAD ch1=3, START ch1 with data=0 → expiry on the 3rd tick, `evt_valid` 2 cycles later with `evt_ch`=1, `run[1]`=0.
- **Periodic:** LOAD ch0=2, START data=1, `evt_ready`=1 → an event every 8 cycles and `run[0]` stays 1. Then STOP → no further events.
- **Round-robin:** ch0, ch2 and ch3 all expire on the same tick, `evt_ready`=1, `ptr`=0 → events are delivered in order 0, 2, 3. A second simultaneous round then starts from 0 again, since `ptr`=0 after ch3 is served.
- **Overrun and CLEAR:** ch1 periodic with reload=1, `evt_ready`=0 → `overrun[1]`=1 after the 2nd tick, and `evt_ch` stays 1. CLEAR ch1 → `overrun[1]`=0 and `evt_valid` drops.
- **Command blocking and edge case:** drive `cmd_valid` in a tick cycle → `cmd_ready`=0 and the command is taken the next cycle. START with reload=0 → `run` stays 0.
